uart_receiver: RTL and testbench

//   8N1-style serial receiver. Consumes the 16x-oversample tick from the shared baud tick generator,

---
 rtl/uart_receiver.sv | 192 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1-style serial receiver. Works from a 16x (SAMPLE_RATE) oversample tick
//   supplied by the shared baud tick generator, pulses start_rx on every
//   detected start edge so the generator can realign its tick phase, samples
//   each bit at its centre and offers the received word on a valid/ready port.
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   rx             in   serial line, idle high, asynchronous to clock
//   tick           in   one-cycle oversample strobe
//   start_rx       out  one-cycle pulse on start-edge detect (IDLE only)
//   data           out  received word, stable while data_valid=1
//   data_valid     out  word available, held until accepted
//   data_ready     in   consumer accepts word when data_valid & data_ready
//   framing_error  out  one-cycle pulse: stop bit sampled low, word discarded
//   overrun        out  one-cycle pulse: new word replaced an unaccepted one
//   state_dbg      out  current FSM state encoding (debug / checker hook)
//
// Handshake: a word is transferred on a rising clock edge where
//   data_valid=1 and data_ready=1. data_valid and data are held stable until
//   that edge, except when a newer word overwrites an unaccepted one (overrun).
//   data_ready while data_valid=0 has no effect.

module uart_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RATE = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 tick,
    output logic                 start_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic [2:0]           state_dbg
);

    localparam int CW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(SAMPLE_RATE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tick_last;
    logic                 sample_bit;
    logic                 word_done;
    logic                 frame_bad;

    assign state_dbg = state;
    assign tick_last = tick && (tick_cnt == LAST_CNT);

    // Two-flop synchronizer plus one history flop for edge detection.
    // Preset to 1 so reset does not look like a falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_rx   = 1'b0;
        sample_bit = 1'b0;
        word_done  = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    start_rx   = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                // Start-bit centre: a line back high here was a glitch.
                if (tick && (tick_cnt == HALF_CNT)) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    sample_bit = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Returning to IDLE at the stop-bit centre leaves half a bit
                // to catch a back-to-back start edge.
                if (tick_last) begin
                    if (rx_s) begin
                        word_done  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Tick counter restarts on every state change; this also makes start_rx
    // win over a coincident tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (state_next != state) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (sample_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // LSB arrives first: shift in at the MSB, move right.
            if (sample_bit) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= 1'b0;
            if (word_done) begin
                // A word landing on the acceptance edge is not an overrun.
                data       <= shift_reg;
                data_valid <= 1'b1;
                overrun    <= data_valid && !data_ready;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed bench for uart_receiver (DATA_BITS=8, SAMPLE_RATE=16).
//   A local tick generator realigns on start_rx like the shared one does;
//   a short tick period keeps run time small. Inputs change on the falling
//   clock edge; the monitor samples 3 ns later, well clear of the rising edge.

module tb_uart_receiver;

    localparam int TICK_DIV = 11;
    localparam int BIT      = TICK_DIV * 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       tick;
    logic       start_rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       framing_error;
    logic       overrun;
    logic [2:0] state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int n_start     = 0;
    int n_ferr      = 0;
    int n_ovr       = 0;
    int n_valid     = 0;
    int tcnt        = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_receiver #(.DATA_BITS(8), .SAMPLE_RATE(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx            (rx),
        .tick          (tick),
        .start_rx      (start_rx),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- tick generator (resyncs on start_rx) ----------------
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clock);
            if (start_rx) begin
                tcnt = 0;
                tick = 1'b0;
            end else if (tcnt == TICK_DIV - 1) begin
                tcnt = 0;
                tick = 1'b1;
            end else begin
                tcnt++;
                tick = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (reset_n) begin
                if (start_rx)      n_start++;
                if (framing_error) n_ferr++;
                if (overrun)       n_ovr++;
                if (data_valid)    n_valid++;
                if (data_valid && data_ready) got_q.push_back(data);
            end
        end
    end

    // ---------------- scoreboard / checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_words(input string tag);
        logic [7:0] g;
        logic [7:0] e;
        check({tag, "_word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_word"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_stats();
        n_start = 0;
        n_ferr  = 0;
        n_ovr   = 0;
        n_valid = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},          32'(data),          32'h0);
        check({tag, "_data_valid"},    32'(data_valid),    32'h0);
        check({tag, "_start_rx"},      32'(start_rx),      32'h0);
        check({tag, "_framing_error"}, 32'(framing_error), 32'h0);
        check({tag, "_overrun"},       32'(overrun),       32'h0);
        check({tag, "_state"},         32'(state_dbg),     32'h0);
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] partial;
        rx         = 1'b1;
        data_ready = 1'b1;
        reset_n    = 1'b0;
        idle(5);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle(20);

        // 1: single frame 0xA5
        clear_stats();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(2 * BIT);
        compare_words("t1");
        check("t1_start_pulses", 32'(n_start), 32'd1);
        check("t1_valid_cycles", 32'(n_valid), 32'd1);
        check("t1_framing",      32'(n_ferr),  32'd0);
        check("t1_overrun",      32'(n_ovr),   32'd0);

        // 2: 4-tick low glitch is rejected at the start-bit centre
        clear_stats();
        rx = 1'b0;
        idle(4 * TICK_DIV);
        rx = 1'b1;
        idle(2 * BIT);
        check("t2_start_pulses", 32'(n_start),   32'd1);
        check("t2_valid_cycles", 32'(n_valid),   32'd0);
        check("t2_framing",      32'(n_ferr),    32'd0);
        check("t2_state_idle",   32'(state_dbg), 32'd0);

        // 3: stop bit low, line low one more bit, then a good frame
        clear_stats();
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0);
        rx = 1'b1;
        idle(2 * BIT);
        check("t3_framing",      32'(n_ferr),    32'd1);
        check("t3_valid_cycles", 32'(n_valid),   32'd0);
        check("t3_state_idle",   32'(state_dbg), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(2 * BIT);
        compare_words("t3");
        check("t3_framing_after", 32'(n_ferr),  32'd1);
        check("t3_start_pulses",  32'(n_start), 32'd2);

        // 4: consumer stalled, second word overruns the first
        clear_stats();
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(BIT);
        send_frame(8'h22, 1'b1);
        idle(2 * BIT);
        check("t4_valid_held", 32'(data_valid), 32'd1);
        check("t4_data",       32'(data),       32'h22);
        check("t4_overrun",    32'(n_ovr),      32'd1);
        check("t4_framing",    32'(n_ferr),     32'd0);
        check("t4_no_accept",  32'(got_q.size()), 32'd0);
        data_ready = 1'b1;
        exp_q.push_back(8'h22);
        @(posedge clock);
        #1;
        check("t4_valid_drop", 32'(data_valid), 32'd0);
        idle(5);
        compare_words("t4");

        // 5: back-to-back frames with no idle gap
        clear_stats();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(2 * BIT);
        compare_words("t5");
        check("t5_start_pulses", 32'(n_start), 32'd3);
        check("t5_valid_cycles", 32'(n_valid), 32'd3);
        check("t5_framing",      32'(n_ferr),  32'd0);
        check("t5_overrun",      32'(n_ovr),   32'd0);

        // 6: reset during bit 4 of 0x96, then 0x69
        clear_stats();
        partial = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx = partial[4];
        idle(BIT / 2);
        reset_n = 1'b0;
        idle(3);
        check_reset_outputs("t6_in_reset");
        rx = 1'b1;
        idle(10);
        reset_n = 1'b1;
        idle(20);
        clear_stats();
        exp_q.push_back(8'h69);
        send_frame(8'h69, 1'b1);
        idle(2 * BIT);
        compare_words("t6");
        check("t6_start_pulses", 32'(n_start), 32'd1);
        check("t6_framing",      32'(n_ferr),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
